// File: rtl/fib_store_checker_pkg.sv
// Shared types and constants for the Fibonacci store checker.
// Holds FSM state, failure codes and store-window helpers.
package fib_check_pkg;

  typedef enum logic [1:0] {
    CHECK,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_DATA,
    FC_ORDER,
    FC_TIMEOUT
  } fail_code_t;

  localparam int WORD_BYTES  = 4;
  localparam int OUT_LATENCY = 1;

  // Byte span from F(0) to the last byte of F(count-1).
  function automatic int win_span(input int count);
    return WORD_BYTES * count - 1;
  endfunction

endpackage

// File: rtl/fib_store_checker_if.sv
// Data-memory store port between the computer and the checker.
// master: computer side; slave: checker side.
interface fib_store_checker_if #(
  parameter int WIDTH = 32
) ();

  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata
  );

  modport slave (
    input memwrite,
    input dataadr,
    input writedata
  );

endinterface

// File: rtl/fib_term_gen.sv
// Fibonacci pair register; a is the next term the checker expects.
// Ports: clk, reset (async, low), advance, clear, a.
module fib_term_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  output logic [WIDTH-1:0] a
);

  logic [WIDTH-1:0] b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a <= '0;
      b <= WIDTH'(1);
    end else if (clear) begin
      a <= '0;
      b <= WIDTH'(1);
    end else if (advance) begin
      a <= b;
      b <= a + b;
    end
  end

endmodule

// File: rtl/fib_store_checker.sv
// Scoreboard for the Fibonacci program's stores; sticky verdict.
// Ports: clk, reset (async, low), st (store port), status/diagnostics.
module fib_store_checker
  import fib_check_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BASE_ADDR      = 100,
  parameter int COUNT          = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int IDX_W          = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  fib_store_checker_if.slave   st,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [IDX_W-1:0]     fail_index,
  output logic [WIDTH-1:0]     fail_expected,
  output logic [WIDTH-1:0]     fail_got,
  output logic [IDX_W-1:0]     checked
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WIDTH-1:0] WIN_LO =
    WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] WIN_TOP =
    WIDTH'(BASE_ADDR + win_span(COUNT));
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(COUNT - 1);

  state_t           state_q;
  state_t           state_d;
  fail_code_t       code_d;
  fail_code_t       code_q;

  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] exp_addr_q;
  logic [WIDTH-1:0] term;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  logic [IDX_W-1:0] fidx_q;
  logic [WIDTH-1:0] fexp_q;
  logic [WIDTH-1:0] fgot_q;

  logic in_win;
  logic hit;
  logic addr_ok;
  logic data_ok;
  logic last;
  logic tmo;
  logic advance;
  logic to_fail;

  assign in_win  = (st.dataadr >= WIN_LO) &&
                   (st.dataadr <= WIN_TOP);
  assign hit     = st.memwrite && in_win;
  assign addr_ok = st.dataadr == exp_addr_q;
  assign data_ok = st.writedata == term;
  assign last    = idx_q == IDX_LAST;

  // Counter saturates; tmo flags the edge it first lands on the limit.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign tmo     = (cnt_inc == CNT_MAX) && (cnt_q != CNT_MAX);

  fib_term_gen #(
    .WIDTH(WIDTH)
  ) u_term (
    .clk    (clk),
    .reset  (reset),
    .advance(advance),
    .clear  (1'b0),
    .a      (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CHECK;
    else        state_q <= state_d;
  end

  // A store verdict outranks a timeout landing on the same edge.
  always_comb begin
    state_d = state_q;
    code_d  = FC_NONE;
    unique case (state_q)
      CHECK: begin
        if (hit && !addr_ok) begin
          state_d = FAIL;
          code_d  = FC_ORDER;
        end else if (hit && !data_ok) begin
          state_d = FAIL;
          code_d  = FC_DATA;
        end else if (hit && last) begin
          state_d = PASS;
        end else if (tmo) begin
          state_d = FAIL;
          code_d  = FC_TIMEOUT;
        end
      end
      PASS:    state_d = PASS;
      FAIL:    state_d = FAIL;
      default: state_d = CHECK;
    endcase
  end

  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    unique case (state_q)
      PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      FAIL: begin
        done = 1'b1;
        fail = 1'b1;
      end
      default: ;
    endcase
  end

  assign advance = (state_q == CHECK) &&
                   (state_d == CHECK) &&
                   hit && addr_ok && data_ok;
  assign to_fail = (state_q == CHECK) &&
                   (state_d == FAIL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      exp_addr_q <= WIN_LO;
      cnt_q      <= '0;
      code_q     <= FC_NONE;
      fidx_q     <= '0;
      fexp_q     <= '0;
      fgot_q     <= '0;
    end else begin
      if (state_q == CHECK) cnt_q <= cnt_inc;
      if (advance) begin
        idx_q      <= idx_q + 1'b1;
        exp_addr_q <= exp_addr_q + WIDTH'(WORD_BYTES);
      end
      if (to_fail) begin
        code_q <= code_d;
        fidx_q <= idx_q;
        fexp_q <= term;
        fgot_q <= (code_d == FC_TIMEOUT) ? '0 : st.writedata;
      end
    end
  end

  assign fail_code     = code_q;
  assign fail_index    = fidx_q;
  assign fail_expected = fexp_q;
  assign fail_got      = fgot_q;
  assign checked       = pass ? IDX_W'(COUNT) : idx_q;

endmodule

// File: tb/tb_fib_store_checker.sv
// Randomized + directed bench for fib_store_checker.
// Behavioural model by term number; compared every negedge.
module tb_fib_store_checker;

  localparam int W    = 32;
  localparam int BASE = 100;
  localparam int CNT  = 10;
  localparam int TMO  = 1000;
  localparam int IW   = $clog2(CNT + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fib_store_checker_if #(.WIDTH(W)) bus ();

  logic          done;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [IW-1:0] fail_index;
  logic [W-1:0]  fail_expected;
  logic [W-1:0]  fail_got;
  logic [IW-1:0] checked;

  fib_store_checker #(
    .WIDTH         (W),
    .BASE_ADDR     (BASE),
    .COUNT         (CNT),
    .TIMEOUT_CYCLES(TMO),
    .IDX_W         (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .st           (bus),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .fail_code    (fail_code),
    .fail_index   (fail_index),
    .fail_expected(fail_expected),
    .fail_got     (fail_got),
    .checked      (checked)
  );

  int tests = 0;
  int fails = 0;

  // Model: m_st 0 checking, 1 passed, 2 failed.
  int       m_st    = 0;
  int       m_idx   = 0;
  int       m_edges = 0;
  int       m_fc    = 0;
  int       m_fi    = 0;
  logic [W-1:0] m_fe = '0;
  logic [W-1:0] m_fg = '0;

  function automatic logic [W-1:0] fib(input int n);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = '0;
    y = 1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  logic         in_w;
  logic [W-1:0] want_adr;
  assign in_w = bus.memwrite &&
                bus.dataadr >= 32'(BASE) &&
                bus.dataadr < 32'(BASE + 4 * CNT);
  assign want_adr = 32'(BASE + 4 * m_idx);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st    <= 0;
      m_idx   <= 0;
      m_edges <= 0;
      m_fc    <= 0;
      m_fi    <= 0;
      m_fe    <= '0;
      m_fg    <= '0;
    end else if (m_st == 0) begin
      m_edges <= m_edges + 1;
      if (in_w && bus.dataadr != want_adr) begin
        m_st <= 2; m_fc <= 2; m_fi <= m_idx;
        m_fe <= fib(m_idx); m_fg <= bus.writedata;
      end else if (in_w && bus.writedata != fib(m_idx)) begin
        m_st <= 2; m_fc <= 1; m_fi <= m_idx;
        m_fe <= fib(m_idx); m_fg <= bus.writedata;
      end else if (in_w && m_idx == CNT - 1) begin
        m_st <= 1;
      end else if (m_edges + 1 == TMO - 1) begin
        m_st <= 2; m_fc <= 3; m_fi <= m_idx;
        m_fe <= fib(m_idx); m_fg <= '0;
      end else if (in_w) begin
        m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("done", done, m_st != 0);
    chk("pass", pass, m_st == 1);
    chk("fail", fail, m_st == 2);
    chk("fail_code", fail_code, m_fc);
    chk("fail_index", fail_index, m_fi);
    chk("fail_expected", fail_expected, m_fe);
    chk("fail_got", fail_got, m_fg);
    chk("checked", checked, (m_st == 1) ? CNT : m_idx);
  end

  task automatic put(input logic [W-1:0] a,
                     input logic [W-1:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.memwrite  = 1'b0;
    bus.dataadr   = $urandom;
    bus.writedata = $urandom;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.memwrite = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic golden(input int from, input int upto, input int gap);
    for (int k = from; k < upto; k++) begin
      put(32'(BASE + 4 * k), fib(k));
      idle(gap);
    end
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done; i++) @(negedge clk);
    chk("wait_done", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_checked", checked, 0);
    chk("rst_code", fail_code, 0);

    // Golden run, one store per 3 cycles.
    golden(0, CNT, 2);
    chk("gold_pass", pass, 1);
    chk("gold_fail", fail, 0);
    chk("gold_checked", checked, 10);

    // Data mismatch at term 3, later stores ignored.
    do_reset();
    golden(0, 3, 2);
    put(112, 3);
    idle(2);
    chk("mm_code", fail_code, 1);
    chk("mm_index", fail_index, 3);
    chk("mm_exp", fail_expected, 2);
    chk("mm_got", fail_got, 3);
    chk("mm_checked", checked, 3);
    golden(4, CNT, 1);
    chk("mm_frozen_code", fail_code, 1);
    chk("mm_frozen_got", fail_got, 3);
    chk("mm_frozen_pass", pass, 0);

    // Skipped term.
    do_reset();
    put(100, 0);
    put(104, 1);
    put(112, 7);
    idle(2);
    chk("skip_code", fail_code, 2);
    chk("skip_index", fail_index, 2);

    // Misaligned first store.
    do_reset();
    put(102, 0);
    idle(2);
    chk("mis_code", fail_code, 2);
    chk("mis_index", fail_index, 0);
    chk("mis_got", fail_got, 0);

    // Out-of-window noise.
    do_reset();
    for (int k = 0; k < CNT; k++) begin
      put(0, $urandom);
      put(96, $urandom);
      put(32'(BASE + 4 * k), fib(k));
      put(140, $urandom);
      put(200, $urandom);
      idle(1);
    end
    chk("noise_pass", pass, 1);

    // Timeout after three good terms.
    do_reset();
    golden(0, 3, 0);
    idle(1);
    wait_done(1100);
    chk("tmo_code", fail_code, 3);
    chk("tmo_index", fail_index, 3);
    chk("tmo_exp", fail_expected, 2);
    chk("tmo_got", fail_got, 0);
    chk("tmo_edge", 32'(m_edges), 999);

    // Bad store on the timeout edge wins.
    do_reset();
    golden(0, 3, 0);
    idle(1);
    for (int i = 0; i < 1100 && m_edges < TMO - 2; i++)
      @(negedge clk);
    put(112, 5);
    idle(2);
    chk("tie_code", fail_code, 1);
    chk("tie_got", fail_got, 5);
    chk("tie_index", fail_index, 3);

    // Asynchronous reset mid-check.
    do_reset();
    golden(0, 5, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_checked", checked, 0);
    chk("async_done", done, 0);
    chk("async_code", fail_code, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    golden(0, CNT, 2);
    chk("async_pass", pass, 1);
    chk("async_n", checked, 10);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      int mode;
      int bad;
      logic [W-1:0] a;
      logic [W-1:0] d;
      do_reset();
      mode = $urandom_range(0, 2);
      bad  = $urandom_range(0, CNT - 1);
      for (int k = 0; k < CNT; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: put(0, $urandom);
            1: put(96, $urandom);
            2: put(140, $urandom);
            default: put(32'($urandom_range(140, 4000)), $urandom);
          endcase
        end
        a = 32'(BASE + 4 * k);
        d = fib(k);
        if (mode == 1 && k == bad)
          d = d ^ 32'($urandom_range(1, 255));
        if (mode == 2 && k == bad) begin
          case ($urandom_range(0, 2))
            0: a = a + 2;
            1: a = a + 4;
            default: a = a - 4;
          endcase
        end
        put(a, d);
        idle($urandom_range(0, 3));
      end
      idle(2);
      if (mode == 0) chk("rand_pass", pass, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
